// File: rtl/uart_rx_os16_pkg.sv
// rtl/uart_rx_os16_pkg.sv - shared UART constants, state encoding and divider helper
package uart_rx_os16_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRK   = 3'd4
    } state_t;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running sample-tick generator, one pulse every DIV clocks
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk_50m,
    input  logic rst_n,
    output logic tick
);

    localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x oversampling 8N1 UART receiver with majority vote and error flags
module uart_rx_os16
    import uart_rx_os16_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rdy_clr,
    output logic       rdy,
    output logic [7:0] dout,
    output logic       frame_err,
    output logic       overrun
);

    localparam int         DIV    = calc_div(CLK_HZ, BAUD);
    localparam logic [3:0] SC_END = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] IDX_END = 3'(DATA_BITS - 1);

    logic       rx_meta;
    logic       rx_s;
    logic       tick;
    logic [3:0] sc;
    logic [2:0] idx;
    logic       s7;
    logic       s8;
    logic [7:0] shreg;
    logic       maj;
    logic       at_mid;
    logic       at_end;
    logic       shift_en;
    logic       done;
    logic       ferr_set;
    state_t     state;
    state_t     state_n;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .tick    (tick)
    );

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Third vote is the live sc=9 sample, so the decision lands on that tick.
    assign maj    = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    assign at_mid = tick && (sc == 4'd9);
    assign at_end = tick && (sc == SC_END);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sc  <= '0;
            idx <= '0;
            s7  <= 1'b1;
            s8  <= 1'b1;
        end else begin
            if (tick) begin
                if (state == ST_IDLE && !rx_s) begin
                    sc <= '0;
                end else begin
                    sc <= sc + 1'b1;
                end
                if (sc == 4'd7) s7 <= rx_s;
                if (sc == 4'd8) s8 <= rx_s;
            end
            if (state == ST_START && at_end) begin
                idx <= '0;
            end else if (state == ST_DATA && at_end) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (tick && !rx_s) state_n = ST_START;
            ST_START: begin
                if (at_mid && maj)   state_n = ST_IDLE;
                else if (at_end)     state_n = ST_DATA;
            end
            ST_DATA:  if (at_end && idx == IDX_END) state_n = ST_STOP;
            ST_STOP:  if (at_mid) state_n = maj ? ST_IDLE : ST_BRK;
            ST_BRK:   if (tick && rx_s) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_en = 1'b0;
        done     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            ST_DATA: shift_en = at_mid;
            ST_STOP: begin
                done     = at_mid & maj;
                ferr_set = at_mid & ~maj;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= {maj, shreg[7:1]};
        end
    end

    // A set in the same clock as rdy_clr wins; overrun is never raised by such a completion.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rdy       <= 1'b0;
            dout      <= 8'h00;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (done) begin
                dout <= shreg;
                rdy  <= 1'b1;
            end else if (rdy_clr) begin
                rdy  <= 1'b0;
            end

            if (ferr_set)     frame_err <= 1'b1;
            else if (rdy_clr) frame_err <= 1'b0;

            if (rdy_clr)          overrun <= 1'b0;
            else if (done && rdy) overrun <= 1'b1;
        end
    end

endmodule
